// File: rtl/counter_pkg.sv
// Shared encodings for the command-driven counter: opcode enum and response layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package counter_pkg;

  // Default counter width; the external reference model uses the same encodings.
  localparam int CNT_WIDTH = 7;

  // Command opcodes; value 7 is reserved and behaves like NOP.
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_CLEAR = 3'd1,
    OP_LOAD  = 3'd2,
    OP_INC   = 3'd3,
    OP_DEC   = 3'd4,
    OP_ADD   = 3'd5,
    OP_READ  = 3'd6,
    OP_RSVD  = 3'd7
  } op_t;

  // One response entry. The FIFO word in counter_cmd_unit uses this exact
  // bit order ({op, count, flag}) for any WIDTH.
  typedef struct packed {
    op_t                  op;
    logic [CNT_WIDTH-1:0] count;
    logic                 flag;
  } rsp_t;

  localparam int RSP_W = $bits(rsp_t);

endpackage

// File: rtl/cmd_rsp_fifo.sv
// Synchronous FIFO holding counter responses, DEPTH entries of W bits.
// Latency: a push at edge N is visible at the head in cycle N+1.
// Backpressure: full blocks push unless a pop happens in the same cycle; empty ignores pop.
module cmd_rsp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop & ~empty;
  // A pop frees a slot this cycle, so a push at full is still safe.
  assign do_push = push & (~full | do_pop);

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage write; contents need no reset because empty masks the head downstream.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/counter_cmd_unit.sv
// Command-driven WIDTH-bit counter; every accepted command yields one queued response.
// Latency: command accepted at edge N updates count and pushes its response at edge N; head valid in N+1.
// Backpressure: cmd_ready drops only when the response FIFO holds DEPTH entries (registered state only).
// Build option: define COUNTER_SATURATE_EN for clamping INC/DEC/ADD instead of wrapping.
module counter_cmd_unit
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2:0]       rsp_op,
  output logic [WIDTH-1:0] rsp_count,
  output logic             rsp_flag
);

  localparam int RW = 3 + WIDTH + 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [WIDTH-1:0] MAX_V = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  op_t              op;
  logic [WIDTH-1:0] count_q, count_d;
  logic             flag_d;
  logic [WIDTH:0]   sum_w;
  logic             accept;
  logic             pop;
  logic [RW-1:0]    push_dat;
  logic [RW-1:0]    head_dat;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_cnt;

  assign op     = op_t'(cmd_op);
  // Carry-out of ADD lands in bit WIDTH.
  assign sum_w  = {1'b0, count_q} + {1'b0, cmd_data};

  // Ready depends only on registered occupancy, never on rsp_ready.
  assign cmd_ready = (fifo_cnt < CW'(DEPTH));
  assign accept    = cmd_valid & cmd_ready;
  assign pop       = rsp_valid & rsp_ready;

  // Opcode decode: next count and wrap/saturate flag for the command on the port.
  always_comb begin
    count_d = count_q;
    flag_d  = 1'b0;
    case (op)
      OP_CLEAR: count_d = '0;
      OP_LOAD:  count_d = cmd_data;
      OP_INC: begin
`ifdef COUNTER_SATURATE_EN
        if (count_q == MAX_V) flag_d  = 1'b1;
        else                  count_d = count_q + ONE_V;
`else
        count_d = count_q + ONE_V;
        flag_d  = (count_q == MAX_V);
`endif
      end
      OP_DEC: begin
`ifdef COUNTER_SATURATE_EN
        if (count_q == '0) flag_d  = 1'b1;
        else               count_d = count_q - ONE_V;
`else
        count_d = count_q - ONE_V;
        flag_d  = (count_q == '0);
`endif
      end
      OP_ADD: begin
`ifdef COUNTER_SATURATE_EN
        if (sum_w[WIDTH]) begin
          count_d = MAX_V;
          flag_d  = 1'b1;
        end else begin
          count_d = sum_w[WIDTH-1:0];
        end
`else
        count_d = sum_w[WIDTH-1:0];
        flag_d  = sum_w[WIDTH];
`endif
      end
      // NOP, READ and the reserved opcode leave the count alone.
      default: count_d = count_q;
    endcase
  end

  // Counter register: only accepted commands may change it.
  always_ff @(posedge clk) begin
    if (rst)         count_q <= '0;
    else if (accept) count_q <= count_d;
  end

  // Raw opcode is echoed so the reserved value 7 is reported as-is.
  assign push_dat = {cmd_op, count_d, flag_d};

  cmd_rsp_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept & ~fifo_full),
    .din   (push_dat),
    .pop   (pop),
    .dout  (head_dat),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Head is forced to zero while empty so reset and idle show all-zero responses.
  assign rsp_valid = ~fifo_empty;
  assign {rsp_op, rsp_count, rsp_flag} = fifo_empty ? '0 : head_dat;

endmodule

// File: tb/tb_counter_cmd_unit.sv
// Self-checking bench for counter_cmd_unit with a queue-based reference model.
// Latency: n/a.
// Backpressure: exercised by holding rsp_ready low and by random ready patterns.
module tb_counter_cmd_unit;
  import counter_pkg::*;

  localparam int W    = 7;
  localparam int D    = 4;
  localparam int MAXV = (1 << W) - 1;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] cnt;
    logic         flag;
  } rsp_s;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [2:0]   rsp_op;
  logic [W-1:0] rsp_count;
  logic         rsp_flag;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   mcount       = 0;
  rsp_s exp_q[$];

  counter_cmd_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_op    (rsp_op),
    .rsp_count (rsp_count),
    .rsp_flag  (rsp_flag)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic, then wrap or clamp into range.
  function automatic void model_apply(input logic [2:0] op, input logic [W-1:0] d);
    int   n;
    int   f;
    rsp_s r;
    f = 0;
    case (op)
      3'd1:    n = 0;
      3'd2:    n = int'(d);
      3'd3:    n = mcount + 1;
      3'd4:    n = mcount - 1;
      3'd5:    n = mcount + int'(d);
      default: n = mcount;
    endcase
`ifdef COUNTER_SATURATE_EN
    if (n > MAXV)   begin n = MAXV; f = 1; end
    else if (n < 0) begin n = 0;    f = 1; end
`else
    if (n > MAXV)   begin n = n - (MAXV + 1); f = 1; end
    else if (n < 0) begin n = n + (MAXV + 1); f = 1; end
`endif
    mcount = n;
    r.op   = op;
    r.cnt  = W'(n);
    r.flag = f[0];
    exp_q.push_back(r);
  endfunction

  function automatic void model_reset();
    mcount = 0;
    exp_q.delete();
  endfunction

  // One clock of stimulus; reports what was accepted/popped and the head seen before the edge.
  task automatic step(input logic v, input logic [2:0] op, input logic [W-1:0] d, input logic rr,
                      output bit acc, output bit popped, output rsp_s seen);
    bit rdy;
    bit rv;
    rdy       = cmd_ready;
    rv        = rsp_valid;
    seen.op   = rsp_op;
    seen.cnt  = rsp_count;
    seen.flag = rsp_flag;
    cmd_valid = v;
    cmd_op    = op;
    cmd_data  = d;
    rsp_ready = rr;
    @(posedge clk); #1;
    acc    = v && rdy;
    popped = rv && rr;
    if (acc) model_apply(op, d);
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    model_reset();
    tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    tests_run++; if (rsp_op !== 3'd0) begin tests_failed++; $display("FAIL reset_rsp_op got=%0d want=0", rsp_op); end
    tests_run++; if (rsp_count !== '0) begin tests_failed++; $display("FAIL reset_rsp_count got=%h want=0", rsp_count); end
    tests_run++; if (rsp_flag !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_flag got=%b want=0", rsp_flag); end
  endtask

  task automatic test_wrap_sequence();
    bit acc, pp;
    rsp_s seen, e;
    logic [2:0]   ops  [4];
    logic [W-1:0] cnts [4];
    logic         flgs [4];
    int k;
    ops = '{3'd2, 3'd3, 3'd3, 3'd4};
`ifdef COUNTER_SATURATE_EN
    cnts = '{7'h7E, 7'h7F, 7'h7F, 7'h7E};
    flgs = '{1'b0, 1'b0, 1'b1, 1'b0};
`else
    cnts = '{7'h7E, 7'h7F, 7'h00, 7'h7F};
    flgs = '{1'b0, 1'b0, 1'b1, 1'b1};
`endif
    step(1'b1, OP_LOAD, 7'h7E, 1'b0, acc, pp, seen);
    step(1'b1, OP_INC,  '0,    1'b0, acc, pp, seen);
    step(1'b1, OP_INC,  '0,    1'b0, acc, pp, seen);
    step(1'b1, OP_DEC,  '0,    1'b0, acc, pp, seen);
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      step(1'b0, OP_NOP, '0, 1'b1, acc, pp, seen);
      if (pp) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        tests_run++;
        if (seen.op !== ops[k] || seen.cnt !== cnts[k] || seen.flag !== flgs[k]) begin
          tests_failed++;
          $display("FAIL wrap_seq[%0d] got=(%0d,%h,%b) want=(%0d,%h,%b)", k, seen.op, seen.cnt, seen.flag, ops[k], cnts[k], flgs[k]);
        end
        k++;
      end
    end
    tests_run++; if (k != 4) begin tests_failed++; $display("FAIL wrap_seq_count got=%0d want=4", k); end
  endtask

  task automatic test_backpressure();
    bit acc, pp;
    rsp_s seen, e;
    int accepted, remaining, k;
    step(1'b1, OP_CLEAR, '0, 1'b1, acc, pp, seen);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, OP_NOP, '0, 1'b1, acc, pp, seen);
      if (pp && exp_q.size() > 0) e = exp_q.pop_front();
    end
    accepted = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, OP_INC, '0, 1'b0, acc, pp, seen);
      if (acc) accepted++;
    end
    tests_run++; if (accepted != 4) begin tests_failed++; $display("FAIL bp_accepted got=%0d want=4", accepted); end
    tests_run++; if (cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_cmd_ready got=%b want=0", cmd_ready); end
    tests_run++; if (mcount != 4) begin tests_failed++; $display("FAIL bp_model_count got=%0d want=4", mcount); end
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_op !== 3'd3 || rsp_count !== 7'd1) begin
      tests_failed++;
      $display("FAIL bp_head_held got=(%b,%0d,%h) want=(1,3,01)", rsp_valid, rsp_op, rsp_count);
    end
    remaining = 6 - accepted;
    k = 0;
    for (int c = 0; c < 40 && k < 6; c++) begin
      step(remaining > 0, OP_INC, '0, 1'b1, acc, pp, seen);
      if (acc) remaining--;
      if (pp) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        tests_run++;
        if (seen.op !== 3'd3 || seen.cnt !== W'(k + 1) || seen.flag !== 1'b0) begin
          tests_failed++;
          $display("FAIL bp_order[%0d] got=(%0d,%h,%b) want=(3,%h,0)", k, seen.op, seen.cnt, seen.flag, W'(k + 1));
        end
        k++;
      end
    end
    tests_run++; if (k != 6) begin tests_failed++; $display("FAIL bp_delivered got=%0d want=6", k); end
  endtask

  task automatic test_full_pushpop();
    bit acc, pp;
    rsp_s seen, e;
    int pushed, popped;
    for (int c = 0; c < 6; c++) step(1'b1, OP_INC, '0, 1'b0, acc, pp, seen);
    tests_run++; if (cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL full_ready got=%b want=0", cmd_ready); end
    pushed = exp_q.size();
    popped = 0;
    for (int c = 0; c < 80; c++) begin
      bit more;
      more = (c < 30);
      step(more, 3'($urandom_range(0, 7)), W'($urandom_range(0, MAXV)), 1'b1, acc, pp, seen);
      if (acc) pushed++;
      if (pp) begin
        popped++;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL full_extra got=(%0d,%h,%b) want=none", seen.op, seen.cnt, seen.flag);
        end else begin
          e = exp_q.pop_front();
          if (seen.op !== e.op || seen.cnt !== e.cnt || seen.flag !== e.flag) begin
            tests_failed++;
            $display("FAIL full_rsp got=(%0d,%h,%b) want=(%0d,%h,%b)", seen.op, seen.cnt, seen.flag, e.op, e.cnt, e.flag);
          end
        end
      end
      if (!more && exp_q.size() == 0 && !rsp_valid) break;
    end
    tests_run++; if (popped != pushed) begin tests_failed++; $display("FAIL full_totals got=%0d want=%0d", popped, pushed); end
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL full_drained got=%b want=0", rsp_valid); end
  endtask

  task automatic test_add();
    bit acc, pp;
    rsp_s seen, e;
    int k;
    step(1'b1, OP_LOAD, 7'h40, 1'b0, acc, pp, seen);
    step(1'b1, OP_ADD,  7'h50, 1'b0, acc, pp, seen);
    k = 0;
    for (int c = 0; c < 20 && k < 2; c++) begin
      step(1'b0, OP_NOP, '0, 1'b1, acc, pp, seen);
      if (pp) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        if (k == 1) begin
          tests_run++;
`ifdef COUNTER_SATURATE_EN
          if (seen.op !== 3'd5 || seen.cnt !== 7'h7F || seen.flag !== 1'b1) begin
            tests_failed++; $display("FAIL add_carry got=(%0d,%h,%b) want=(5,7f,1)", seen.op, seen.cnt, seen.flag);
          end
`else
          if (seen.op !== 3'd5 || seen.cnt !== 7'h10 || seen.flag !== 1'b1) begin
            tests_failed++; $display("FAIL add_carry got=(%0d,%h,%b) want=(5,10,1)", seen.op, seen.cnt, seen.flag);
          end
`endif
        end
        k++;
      end
    end
    tests_run++; if (k != 2) begin tests_failed++; $display("FAIL add_delivered got=%0d want=2", k); end
  endtask

  task automatic test_reset_midstream();
    bit acc, pp;
    rsp_s seen;
    for (int c = 0; c < 3; c++) step(1'b1, OP_INC, '0, 1'b0, acc, pp, seen);
    tests_run++; if (exp_q.size() != 3) begin tests_failed++; $display("FAIL mid_queued got=%0d want=3", exp_q.size()); end
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = OP_INC; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    model_reset();
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rsp_valid got=%b want=0", rsp_valid); end
    tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_cmd_ready got=%b want=1", cmd_ready); end
    step(1'b1, OP_READ, 7'h55, 1'b0, acc, pp, seen);
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_op !== 3'd6 || rsp_count !== 7'h00 || rsp_flag !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_read got=(%b,%0d,%h,%b) want=(1,6,00,0)", rsp_valid, rsp_op, rsp_count, rsp_flag);
    end
    step(1'b0, OP_NOP, '0, 1'b1, acc, pp, seen);
    if (pp && exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic test_random();
    bit acc, pp, rv_before, rr;
    rsp_s seen, e;
    for (int c = 0; c < 400; c++) begin
      rv_before = rsp_valid;
      rr = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), W'($urandom_range(0, MAXV)), rr, acc, pp, seen);
      if (pp) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++; $display("FAIL rnd_extra got=(%0d,%h,%b) want=none", seen.op, seen.cnt, seen.flag);
        end else begin
          e = exp_q.pop_front();
          if (seen.op !== e.op || seen.cnt !== e.cnt || seen.flag !== e.flag) begin
            tests_failed++;
            $display("FAIL rnd_rsp got=(%0d,%h,%b) want=(%0d,%h,%b)", seen.op, seen.cnt, seen.flag, e.op, e.cnt, e.flag);
          end
        end
      end else if (rv_before && !rr) begin
        tests_run++;
        if (rsp_op !== seen.op || rsp_count !== seen.cnt || rsp_flag !== seen.flag) begin
          tests_failed++;
          $display("FAIL rnd_hold got=(%0d,%h,%b) want=(%0d,%h,%b)", rsp_op, rsp_count, rsp_flag, seen.op, seen.cnt, seen.flag);
        end
      end
      tests_run++;
      if (cmd_ready !== (exp_q.size() < D) || rsp_valid !== (exp_q.size() > 0)) begin
        tests_failed++;
        $display("FAIL rnd_occupancy got=(rdy %b,vld %b) want=(rdy %b,vld %b)", cmd_ready, rsp_valid, exp_q.size() < D, exp_q.size() > 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_sequence();
    test_backpressure();
    test_full_pushpop();
    test_add();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
